// File: rtl/bj_hand_tracker.sv
// -----------------------------------------------------------------------------
// bj_hand_tracker
//   Tracks a single blackjack hand: hard sum, soft-ace state, card count and
//   game state. Produces registered, display-ready digits for the downstream
//   seven-segment driver.
//
// Optional feature:
//   `define BJ_DUP_CHECK_EN  adds a 52-bit used-card mask; a card id already
//                            taken in the current hand is rejected.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   card_valid   one-cycle pulse, card_id valid this cycle
//   card_id      card 0..51, rank = card_id mod 13
//   more         hit request level, required to take a card in PLAY
//   stand        one-cycle pulse ending the player's turn
//   new_hand     one-cycle pulse clearing the hand and starting a deal
//   card_accept  one-cycle pulse, card taken
//   card_reject  one-cycle pulse, card refused
//   state        IDLE=0 DEAL1=1 DEAL2=2 PLAY=3 STAND=4 BUST=5 BJ=6
//   total        best hand total 0..31
//   card_count   cards in hand
//   bust         high in BUST
//   blackjack    high in BJ
//   disp_digits  {count hex, status code, tens BCD, ones BCD}
// All outputs are registers; a card event at edge N is reflected after N+1.
// -----------------------------------------------------------------------------
module bj_hand_tracker #(
  parameter int unsigned MAX_CARDS  = 11,
  parameter bit          AUTO_STAND = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_valid,
  input  logic [5:0]  card_id,
  input  logic        more,
  input  logic        stand,
  input  logic        new_hand,
  output logic        card_accept,
  output logic        card_reject,
  output logic [2:0]  state,
  output logic [4:0]  total,
  output logic [3:0]  card_count,
  output logic        bust,
  output logic        blackjack,
  output logic [15:0] disp_digits
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAL1 = 3'd1,
    S_DEAL2 = 3'd2,
    S_PLAY  = 3'd3,
    S_STAND = 3'd4,
    S_BUST  = 3'd5,
    S_BJ    = 3'd6
  } state_e;

  // Soft total: an ace counts 11 only if that does not push the hand past 21.
  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  function automatic logic [3:0] status_code(input state_e s);
    case (s)
      S_DEAL1, S_DEAL2: return 4'hD;
      S_PLAY:           return 4'hC;
      S_STAND:          return 4'h5;
      S_BUST:           return 4'hB;
      S_BJ:             return 4'hA;
      default:          return 4'h0;
    endcase
  endfunction

  // Total never exceeds 31, so tens is 0..3.
  function automatic logic [7:0] to_bcd(input logic [4:0] t);
    if (t >= 5'd30)      return {4'd3, 4'(t - 5'd30)};
    else if (t >= 5'd20) return {4'd2, 4'(t - 5'd20)};
    else if (t >= 5'd10) return {4'd1, 4'(t - 5'd10)};
    else                 return {4'd0, 4'(t)};
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  hard_q, hard_d;
  logic        ace_q, ace_d;
  logic [4:0]  total_q, total_d;
  logic [3:0]  count_q, count_d;
  logic        accept_q, accept_d;
  logic        reject_q, reject_d;
  logic        bust_q, bust_d;
  logic        bj_q, bj_d;
  logic [15:0] disp_q, disp_d;

  logic [5:0]  rank;
  logic [4:0]  card_val;
  logic [4:0]  new_hard;
  logic        new_ace;
  logic [4:0]  new_total;
  logic [3:0]  new_count;
  logic        dup;
  logic        can_take;

`ifdef BJ_DUP_CHECK_EN
  logic [51:0] used_q, used_d;
  assign dup = (card_id <= 6'd51) && used_q[card_id];
`else
  assign dup = 1'b0;
`endif

  // Rank by repeated subtraction of the suit size; ids above 51 produce a
  // meaningless rank but are always rejected.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    rank = card_id;
    if (card_id >= 6'd39)      rank = card_id - 6'd39;
    else if (card_id >= 6'd26) rank = card_id - 6'd26;
    else if (card_id >= 6'd13) rank = card_id - 6'd13;

    if (rank == 6'd0)      card_val = 5'd1;
    else if (rank <= 6'd9) card_val = 5'(rank + 6'd1);
    else                   card_val = 5'd10;
  end

  // Hard sum tops out at 31 because cards are only taken from totals <= 21.
  assign new_hard  = 5'({1'b0, hard_q} + {1'b0, card_val});
  assign new_ace   = ace_q | (rank == 6'd0);
  assign new_total = best_total(new_hard, new_ace);
  assign new_count = count_q + 4'd1;

  assign can_take = (card_id <= 6'd51) && (count_q < 4'(MAX_CARDS)) && !dup &&
                    ((state_q == S_DEAL1) || (state_q == S_DEAL2) ||
                     ((state_q == S_PLAY) && more));

  always_comb begin
    state_d  = state_q;
    hard_d   = hard_q;
    ace_d    = ace_q;
    count_d  = count_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
`ifdef BJ_DUP_CHECK_EN
    used_d   = used_q;
`endif

    if (new_hand) begin
      // new_hand outranks any card arriving in the same cycle.
      state_d  = S_DEAL1;
      hard_d   = '0;
      ace_d    = 1'b0;
      count_d  = '0;
      reject_d = card_valid;
`ifdef BJ_DUP_CHECK_EN
      used_d   = '0;
`endif
    end else if ((state_q == S_PLAY) && stand) begin
      state_d  = S_STAND;
      reject_d = card_valid;
    end else if (card_valid) begin
      if (can_take) begin
        accept_d = 1'b1;
        hard_d   = new_hard;
        ace_d    = new_ace;
        count_d  = new_count;
`ifdef BJ_DUP_CHECK_EN
        used_d[card_id] = 1'b1;
`endif
        case (state_q)
          S_DEAL1: state_d = S_DEAL2;
          S_DEAL2: state_d = (new_total == 5'd21) ? S_BJ : S_PLAY;
          S_PLAY: begin
            if (new_total > 5'd21)                      state_d = S_BUST;
            else if (AUTO_STAND && new_total == 5'd21)  state_d = S_STAND;
            else if (new_count == 4'(MAX_CARDS))        state_d = S_STAND;
            else                                        state_d = S_PLAY;
          end
          default: state_d = state_q;
        endcase
      end else begin
        reject_d = 1'b1;
      end
    end

    // Display-side values follow the next state so they land with it.
    total_d = best_total(hard_d, ace_d);
    bust_d  = (state_d == S_BUST);
    bj_d    = (state_d == S_BJ);
    disp_d  = {count_d, status_code(state_d), to_bcd(total_d)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q  <= S_IDLE;
      hard_q   <= '0;
      ace_q    <= 1'b0;
      total_q  <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      bust_q   <= 1'b0;
      bj_q     <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      hard_q   <= hard_d;
      ace_q    <= ace_d;
      total_q  <= total_d;
      count_q  <= count_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      bust_q   <= bust_d;
      bj_q     <= bj_d;
      disp_q   <= disp_d;
    end
  end

`ifdef BJ_DUP_CHECK_EN
  // NOTE: the used-card mask is a plain flop vector, not a RAM, and must start
  // empty after reset, so it carries the async reset like the other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) used_q <= '0;
    else        used_q <= used_d;
  end
`endif

  assign card_accept = accept_q;
  assign card_reject = reject_q;
  assign state       = state_q;
  assign total       = total_q;
  assign card_count  = count_q;
  assign bust        = bust_q;
  assign blackjack   = bj_q;
  assign disp_digits = disp_q;

endmodule

// File: doc/bj_hand_tracker.md
Name: bj_hand_tracker

Overview:
- Tracks one blackjack hand, upstream of the seven-segment display driver.
- Consumes debounced card-select events: a 6-bit card id from the switches, plus hit/stand/new-hand controls.
- Keeps hard sum, soft-ace state, card count and game state.
- Presents registered, display-ready BCD digits and status flags to the display stage.

Parameters:
- MAX_CARDS, 11, maximum cards per hand; reaching it forces STAND.
- AUTO_STAND, 1, when 1 a total of exactly 21 in PLAY forces STAND.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- card_valid  input  1  one-cycle pulse; card_id is valid this cycle.
- card_id  input  6  card 0..51; rank = card_id mod 13.
- more  input  1  hit request level; must be high for a card to be accepted in PLAY.
- stand  input  1  one-cycle pulse ending the player's turn.
- new_hand  input  1  one-cycle pulse that clears the hand and starts a deal.
- card_accept  output  1  one-cycle pulse: card taken.
- card_reject  output  1  one-cycle pulse: card refused.
- state  output  3  IDLE=0, DEAL1=1, DEAL2=2, PLAY=3, STAND=4, BUST=5, BJ=6.
- total  output  5  best hand total, 0..31.
- card_count  output  4  cards in hand.
- bust  output  1  high in BUST.
- blackjack  output  1  high in BJ.
- disp_digits  output  16  {count hex, status code, tens BCD, ones BCD}.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - total, card_count, hard_sum and ace_seen = 0.
  - bust, blackjack, card_accept and card_reject = 0.
  - disp_digits = 16'h0000.
- Card value by rank:
  - rank 0 = Ace, value 1, sets ace_seen.
  - rank 1..9 = value rank+1.
  - rank 10..12 = value 10.
- Arithmetic:
  - hard_sum is 5-bit; its maximum reachable value is 31.
  - total = hard_sum+10 if ace_seen and hard_sum<=11, else hard_sum.
- Latency: card_valid at edge N → card_accept or card_reject, plus updated total, count, state and disp_digits, all registered, visible after edge N+1. Every output is a register.
- Acceptance: a card is accepted only when all of the following hold; otherwise card_reject pulses and nothing else changes.
  - card_id <= 51.
  - card_count < MAX_CARDS.
  - state is DEAL1, DEAL2, or PLAY with more=1.
- Transitions:
  - IDLE: new_hand → DEAL1.
  - DEAL1: accepted card → DEAL2.
  - DEAL2: accepted card → BJ if the new total is 21, else PLAY.
  - PLAY, accepted card, in priority order:
    - new total > 21 → BUST.
    - total == 21 and AUTO_STAND=1 → STAND.
    - card_count == MAX_CARDS → STAND.
    - otherwise stay in PLAY.
  - PLAY: stand pulse → STAND.
  - STAND/BUST/BJ: hold; every card is rejected; new_hand → DEAL1.
  - new_hand in any state (including DEAL1/DEAL2/PLAY): clear sums, count and flags, go to DEAL1.
- Simultaneous events:
  - new_hand + card_valid: new_hand wins; card dropped, card_reject=1.
  - stand + card_valid in PLAY: stand wins; card_reject=1.
  - card_valid during reset: ignored.
- Status code (disp_digits[11:8]): IDLE 0x0, DEAL1/DEAL2 0xD, PLAY 0xC, STAND 0x5, BUST 0xB, BJ 0xA.
- BCD: total is split into tens (0..3) and ones (0..9) and registered alongside total.

Optional Feature:
- Macro: BJ_DUP_CHECK_EN.
- With the macro defined:
  - A 52-bit used-card mask is set on each accepted card.
  - A card whose bit is already set is rejected.
  - The mask is cleared on reset and on new_hand.
- Without the macro: no mask exists, and duplicate ids are accepted as normal cards.

Test Plan:
- Reset, new_hand, then card_id 0 and 12 → card_accept ×2; state=BJ; total=21; blackjack=1; disp_digits=16'h2A21.
- Cards 9, 22, then card 14 with more=1 → totals 10, 20, 22; state=BUST; bust=1; disp_digits=16'h3B22.
- Cards 0 and 4 → state=PLAY, total=16 (soft); card 9 with more=1 → total=16 (hard), state stays PLAY, card_count=3.
- In PLAY: card_id 60 → card_reject, no change; valid card with more=0 → card_reject; stand → STAND, and a subsequent card → card_reject.
- Mid-hand reset=0 for 2 cycles → all outputs 0, state=IDLE; card_valid before new_hand → card_reject.
- With BJ_DUP_CHECK_EN: cards 5, 5 → second rejected, card_count=1, state=DEAL2. Without the macro, the same sequence is accepted, total=12.
